// File: rtl/sfifo_param.sv
// sfifo_param: single-clock parametrised FIFO with fill count, threshold flags and sticky
// overflow/underflow. Define SFIFO_FWFT_EN to build the first-word-fall-through read mode.
module sfifo_param #(
  parameter int DATA_WIDTH    = 48,
  parameter int ADDRESS_WIDTH = 12,
  parameter int AF_LEVEL      = (2 ** ADDRESS_WIDTH) - 4,
  parameter int AE_LEVEL      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_WIDTH:0]  count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d, ram_word;
  logic empty_q, empty_d, full_q, full_d;
  logic af_q, af_d, ae_q, ae_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_acc, rd_acc, ram_rd;

  // wr_en/rd_en are requests; each is accepted only when the registered full/empty
  // seen before the edge allows it, otherwise it is dropped and the sticky error set.
  assign wr_acc   = wr_en && !full_q;
  assign rd_acc   = rd_en && !empty_q;
  assign ram_word = mem[rd_ptr_q];

`ifdef SFIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] mid_q, mid_d;
  logic                  mid_valid_q, mid_valid_d, out_load;
  logic [CW-1:0]         ram_words;

  // Two-stage prefetch: RAM read register (mid) feeds the output register (dout).
  always_comb begin
    out_load    = empty_q || rd_acc;
    ram_words   = count_q - CW'(mid_valid_q) - CW'(!empty_q);
    ram_rd      = (ram_words != '0) && (!mid_valid_q || out_load);
    mid_d       = ram_rd ? ram_word : mid_q;
    mid_valid_d = ram_rd || (mid_valid_q && !out_load);
    dout_d      = dout_q;
    empty_d     = empty_q;
    if (out_load) begin
      empty_d = !mid_valid_q;
      if (mid_valid_q) dout_d = mid_q;
    end
  end

  always_ff @(posedge clk) begin
    mid_q <= mid_d;
  end
`else
  always_comb begin
    ram_rd = rd_acc;
    dout_d = ram_rd ? ram_word : dout_q;
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(ram_rd);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == DEPTH_C);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    // A new error on the same edge as err_clr must survive, so set is applied last.
    overflow_d = overflow_q;
    if (err_clr) overflow_d = 1'b0;
    if (wr_en && full_q) overflow_d = 1'b1;
    underflow_d = underflow_q;
    if (err_clr) underflow_d = 1'b0;
    if (rd_en && empty_q) underflow_d = 1'b1;
`ifndef SFIFO_FWFT_EN
    empty_d = (count_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef SFIFO_FWFT_EN
      mid_valid_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef SFIFO_FWFT_EN
      mid_valid_q <= mid_valid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_sfifo_param.sv
// Bench for sfifo_param (DEPTH=16, AF=12, AE=2): queue model plus dout scoreboard;
// the FWFT sequence is built when SFIFO_FWFT_EN is defined.
module tb_sfifo_param;
  localparam int DW    = 48;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk, rst, wr_en, rd_en, err_clr;
  logic [DW-1:0] din, dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  sfifo_param #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  logic rd_pending = 1'b0;
  logic fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = m_q.size();
    check("count", 64'(count), 64'(n));
    check("full", 64'(full), 64'(n == DEPTH));
`ifndef SFIFO_FWFT_EN
    check("empty", 64'(empty), 64'(n == 0));
`endif
    check("almost_full", 64'(almost_full), 64'(n >= 12));
    check("almost_empty", 64'(almost_empty), 64'(n <= 2));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_udf));
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic ec);
    int  n;
    logic acc_w, acc_r;
    n = m_q.size();
    wr_en = w; rd_en = r; din = d; err_clr = ec;
    acc_w = w && (n < DEPTH);
    acc_r = r && (n > 0);
    rd_pending = acc_r;
    if (w && n == DEPTH) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
    if (r && n == 0) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
    if (acc_r) exp_q.push_back(m_q.pop_front());
    if (acc_w) m_q.push_back(d);
    @(posedge clk); #1;
    check_flags();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1; wr_en = w; rd_en = 1'b0; err_clr = 1'b0; din = 48'h5A5A_5A5A_5A5A;
    rd_pending = 1'b0;
    @(posedge clk); #1;
    m_q.delete(); exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_almost_empty", 64'(almost_empty), 64'd1);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
  endtask

`ifndef SFIFO_FWFT_EN
  // monitor: a read accepted at an edge presents its word on dout after that edge
  always @(posedge clk) begin
    fire = rd_pending;
    #2;
    if (fire) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dout_order: dout=0x%0h with no expected word queued", dout);
      end else begin
        check("dout_order", 64'(dout), 64'(exp_q.pop_front()));
      end
    end
  end
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    @(negedge clk);
    do_reset(1'b0);

    // fill: 17 writes, the last one overflows and is dropped
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      if (i == 16) begin
        check("fill16_count", 64'(count), 64'd16);
        check("fill16_full", 64'(full), 64'd1);
      end
    end
    check("fill17_overflow", 64'(overflow), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("err_clr_overflow", 64'(overflow), 64'd0);

`ifdef SFIFO_FWFT_EN
    do_reset(1'b0);
    // single word: visible two edges after the write, popped one edge later
    step(1'b1, 1'b0, 48'hABCD_EF01_2345, 1'b0);
    check("fwft_empty_w0", 64'(empty), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("fwft_empty_w1", 64'(empty), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("fwft_empty_w2", 64'(empty), 64'd0);
    check("fwft_dout_w2", 64'(dout), 64'hABCD_EF01_2345);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_empty_pop", 64'(empty), 64'd1);
    // back-to-back pops
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(48'hA1 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("fwft_head0", 64'(dout), 64'hA1);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_head1", 64'(dout), 64'hA2);
    check("fwft_nonempty1", 64'(empty), 64'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_head2", 64'(dout), 64'hA3);
    check("fwft_nonempty2", 64'(empty), 64'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_drained", 64'(empty), 64'd1);
    exp_q.delete();
`else
    // drain: words 1..16 in order, then an underflowing read that leaves dout alone
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      if (i == 16) check("drain16_empty", 64'(empty), 64'd1);
    end
    check("drain17_underflow", 64'(underflow), 64'd1);
    check("drain17_dout_hold", 64'(dout), 64'h10);
    step(1'b0, 1'b0, '0, 1'b1);
    check("err_clr_underflow", 64'(underflow), 64'd0);

    // thresholds
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, DW'(48'h300 + i), 1'b0);
      if (i == 10) check("af_at_11", 64'(almost_full), 64'd0);
    end
    check("af_at_12", 64'(almost_full), 64'd1);
    step(1'b0, 1'b1, '0, 1'b0);
    check("af_fall_11", 64'(almost_full), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
    check("ae_at_3", 64'(almost_empty), 64'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("ae_at_2", 64'(almost_empty), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(48'h3A0 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'(48'h400 + i), 1'b0);
    check("rw_hold_count5", 64'(count), 64'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b0);

    // pointer wrap: 40 writes, reads trailing by two
    for (int i = 0; i < 40; i++) step(1'b1, (i >= 2), DW'(48'h1000 + i), 1'b0);
    while (m_q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(48'h2000 + i), 1'b0);
    step(1'b1, 1'b1, 48'h2FFF, 1'b0);
    check("full_rw_overflow", 64'(overflow), 64'd1);
    check("full_rw_count", 64'(count), 64'd15);
    step(1'b0, 1'b0, '0, 1'b1);
    while (m_q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);

    // reset with data present and a concurrent write
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(48'h5000 + i), 1'b0);
    check("pre_rst_count7", 64'(count), 64'd7);
    do_reset(1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("post_rst_count", 64'(count), 64'd0);
`endif

    step(1'b0, 1'b0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
